// File: rtl/adc_acq_sequencer_if.sv
// Control/status bundle between an acquisition controller and adc_acq_sequencer.
// master = controller side (drives requests and config), slave = sequencer side.
`timescale 1ns/1ps
interface adc_acq_sequencer_if #(
  parameter int PERIOD_W = 8,
  parameter int NSAMP_W  = 24
);
  logic                arm;
  logic                sw_trig;
  logic                stop;
  logic [PERIOD_W-1:0] cfg_period;
  logic [NSAMP_W-1:0]  cfg_nsamp;
  logic                adc_start_conv_en;
  logic                adc_word_sync;
  logic                new_sample;
  logic                sample_clk;
  logic [NSAMP_W-1:0]  sample_cnt;
  logic                armed;
  logic                busy;
  logic                done;
  logic                aborted;

  modport master (
    output arm, sw_trig, stop, cfg_period, cfg_nsamp,
    input  adc_start_conv_en, adc_word_sync, new_sample, sample_clk,
    input  sample_cnt, armed, busy, done, aborted
  );

  modport slave (
    input  arm, sw_trig, stop, cfg_period, cfg_nsamp,
    output adc_start_conv_en, adc_word_sync, new_sample, sample_clk,
    output sample_cnt, armed, busy, done, aborted
  );
endinterface

// File: rtl/adc_acq_sequencer.sv
// ADC acquisition sequencer: arm/trigger/stop FSM plus per-period timing strobes.
// Define ADC_ACQ_EXT_TRIG_EN to add the asynchronous ext_trig input (synchronised, rising edge).
`timescale 1ns/1ps
module adc_acq_sequencer #(
  parameter int PERIOD_W = 8,
  parameter int NSAMP_W  = 24
) (
  input  logic data_clk,
  input  logic reset,
`ifdef ADC_ACQ_EXT_TRIG_EN
  input  logic ext_trig,
`endif
  adc_acq_sequencer_if.slave bus
);

  localparam logic [PERIOD_W-1:0] MIN_PERIOD = PERIOD_W'(16);

  typedef enum logic [1:0] {IDLE, ARMED, ACQ, DONE} state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] phase, phase_nxt;
  logic [PERIOD_W-1:0] period_l;
  logic [NSAMP_W-1:0]  nsamp_l;
  logic [NSAMP_W-1:0]  cnt;
  logic                stop_pend;
  logic                aborted_r;
  logic                arm_take;
  logic                trig;
  logic                acq_nxt;
  logic                word_sync_r, new_sample_r, conv_en_r, sample_clk_r;
  logic                armed_r, busy_r, done_r;

`ifdef ADC_ACQ_EXT_TRIG_EN
  // Two-flop synchroniser plus one history flop for the rising-edge detect.
  logic ext_trig_p0, ext_trig_p1, ext_trig_p2;

  always_ff @(posedge data_clk) begin
    if (reset) begin
      ext_trig_p0 <= 1'b0;
      ext_trig_p1 <= 1'b0;
      ext_trig_p2 <= 1'b0;
    end else begin
      ext_trig_p0 <= ext_trig;
      ext_trig_p1 <= ext_trig_p0;
      ext_trig_p2 <= ext_trig_p1;
    end
  end

  assign trig = bus.sw_trig | (ext_trig_p1 & ~ext_trig_p2);
`else
  assign trig = bus.sw_trig;
`endif

  // stop beats arm in the same cycle
  assign arm_take = (state == IDLE) && bus.arm && !bus.stop;

  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    case (state)
      IDLE: begin
        if (arm_take) state_nxt = ARMED;
      end
      ARMED: begin
        if (bus.stop) begin
          state_nxt = IDLE;
        end else if (trig) begin
          state_nxt = ACQ;
          phase_nxt = '0;
        end
      end
      ACQ: begin
        if (phase == period_l - PERIOD_W'(1)) begin
          phase_nxt = '0;
          if (stop_pend || ((nsamp_l != '0) && (cnt == nsamp_l))) state_nxt = DONE;
        end else begin
          phase_nxt = phase + PERIOD_W'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  assign acq_nxt = (state_nxt == ACQ);

  // Configuration is captured only in the accepted arm cycle.
  always_ff @(posedge data_clk) begin
    if (arm_take) begin
      period_l <= (bus.cfg_period < MIN_PERIOD) ? MIN_PERIOD : bus.cfg_period;
      nsamp_l  <= bus.cfg_nsamp;
    end
  end

  always_ff @(posedge data_clk) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      cnt       <= '0;
      stop_pend <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      stop_pend <= acq_nxt && (stop_pend || ((state == ACQ) && bus.stop));
      if (arm_take) begin
        cnt       <= '0;
        aborted_r <= 1'b0;
      end else begin
        if (new_sample_r) cnt <= cnt + NSAMP_W'(1);
        if ((state == ACQ) && (state_nxt == DONE) && stop_pend) aborted_r <= 1'b1;
      end
    end
  end

  // Outputs are decoded from next state/phase so each flop is high while phase equals its slot.
  always_ff @(posedge data_clk) begin
    if (reset) begin
      word_sync_r  <= 1'b0;
      new_sample_r <= 1'b0;
      conv_en_r    <= 1'b0;
      sample_clk_r <= 1'b0;
      armed_r      <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      word_sync_r  <= acq_nxt && (phase_nxt == period_l - PERIOD_W'(4));
      new_sample_r <= acq_nxt && (phase_nxt == period_l - PERIOD_W'(3));
      conv_en_r    <= acq_nxt && (phase_nxt >= period_l - PERIOD_W'(2));
      sample_clk_r <= acq_nxt && (phase_nxt >= (period_l >> 1));
      armed_r      <= (state_nxt == ARMED);
      busy_r       <= acq_nxt;
      done_r       <= (state_nxt == DONE);
    end
  end

  assign bus.adc_word_sync     = word_sync_r;
  assign bus.new_sample        = new_sample_r;
  assign bus.adc_start_conv_en = conv_en_r;
  assign bus.sample_clk        = sample_clk_r;
  assign bus.sample_cnt        = cnt;
  assign bus.armed             = armed_r;
  assign bus.busy              = busy_r;
  assign bus.done              = done_r;
  assign bus.aborted           = aborted_r;

endmodule
